// File: rtl/uart_rx.sv
// 8N1 UART receiver: the line is synchronised, sampled at mid-bit, and each frame ends in
// either a one-cycle byte strobe or a one-cycle frame-error strobe.
`timescale 1ns/1ps
module uart_rx #(
   parameter int unsigned SAMPLE = 104,
   parameter int unsigned HALF   = 52,
   parameter int unsigned CNT_W  = 7
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_frame_err,
   output logic       o_busy
);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   localparam logic [CNT_W-1:0] HalfEnd   = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] SampleEnd = CNT_W'(SAMPLE - 1);

   state_e           state_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic [CNT_W-1:0] timer_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;

   // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         o_valid     <= 1'b0;
         o_data      <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         timer_q     <= timer_q + CNT_W'(1);
         unique case (state_q)
            StIdle: begin
               timer_q <= '0;
               if (!rx_s_q) begin
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (timer_q == HalfEnd) begin
                  timer_q   <= '0;
                  bit_idx_q <= '0;
                  // A line that is high again at mid start bit was only a glitch.
                  state_q   <= rx_s_q ? StIdle : StData;
               end
            end
            StData: begin
               if (timer_q == SampleEnd) begin
                  timer_q   <= '0;
                  shift_q   <= {rx_s_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= StStop;
                  end
               end
            end
            StStop: begin
               if (timer_q == SampleEnd) begin
                  timer_q <= '0;
                  if (rx_s_q) begin
                     o_data  <= shift_q;
                     o_valid <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     o_frame_err <= 1'b1;
                     state_q     <= StBreak;
                  end
               end
            end
            StBreak: begin
               timer_q <= '0;
               if (rx_s_q) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomised frames, checked every cycle against
// a queue of expected strobes derived from what was put on the line.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam real CLK_PER = 83.0;
   localparam real BIT_PER = 8681.0;
   localparam int  HALF    = 52;

   logic       clk  = 1'b0;
   logic       nrst = 1'b0;
   logic       rx   = 1'b1;
   logic       valid;
   logic [7:0] data;
   logic       ferr;
   logic       busy;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      real        t_lo;
      real        t_hi;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] model_data   = 8'h00;
   int         n_cmp        = 0;
   int         n_bad        = 0;
   int         n_valid_seen = 0;
   int         n_ferr_seen  = 0;
   bit         prev_strobe  = 1'b0;

   uart_rx dut (
      .i_clk      (clk),
      .i_nrst     (nrst),
      .i_rx       (rx),
      .o_valid    (valid),
      .o_data     (data),
      .o_frame_err(ferr),
      .o_busy     (busy)
   );

   always #(CLK_PER / 2.0) clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      check(act == req, name, act, req);
   endtask

   // Drive one frame; the expected strobe and its legal time window are queued up front.
   task automatic send_frame(input logic [7:0] b, input bit stop, input real per,
                             input int n_data);
      ev_t ev;
      real t0;
      t0 = $realtime;
      if (n_data == 8) begin
         ev.is_err = !stop;
         ev.data   = b;
         ev.t_lo   = t0 + 9.0 * per;
         ev.t_hi   = t0 + 10.0 * per + 5.0 * CLK_PER;
         exp_q.push_back(ev);
      end
      rx = 1'b0;
      #(per);
      for (int i = 0; i < n_data; i++) begin
         rx = b[i];
         #(per);
      end
      if (n_data == 8) begin
         rx = stop;
         #(per);
      end
   endtask

   task automatic idle_bits(input real n);
      rx = 1'b1;
      #(n * BIT_PER);
   endtask

   always @(negedge clk) begin
      ev_t ev;
      if (!nrst) begin
         check_eq("reset_outputs", 32'({valid, ferr, busy, data}), 32'd0);
         prev_strobe = 1'b0;
      end else begin
         if (valid || ferr) begin
            check(!(valid && ferr), "strobe_exclusive", 32'({valid, ferr}), 32'd0);
            check(!prev_strobe, "strobe_back_to_back", 32'(prev_strobe), 32'd0);
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_strobe", 32'({valid, ferr}), 32'd0);
            end else begin
               ev = exp_q.pop_front();
               check_eq("strobe_kind_ferr", 32'(ferr), 32'(ev.is_err));
               check($realtime >= ev.t_lo && $realtime <= ev.t_hi, "strobe_time",
                     32'(int'($realtime)), 32'(int'(ev.t_lo)));
               if (valid && !ev.is_err) model_data = ev.data;
            end
            if (valid) n_valid_seen++;
            else n_ferr_seen++;
         end else if (exp_q.size() > 0 && $realtime > exp_q[0].t_hi) begin
            check(1'b0, "missed_strobe", 32'(int'($realtime)), 32'(int'(exp_q[0].t_hi)));
            void'(exp_q.pop_front());
         end
         check_eq("data_hold", 32'(data), 32'(model_data));
         prev_strobe = valid || ferr;
      end
   end

   initial begin
      #7_500_000;
      $display("FAIL watchdog: simulation time limit reached, %0d strobes pending", exp_q.size());
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int  v0;
      real per;
      bit  bad;
      repeat (5) @(negedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      check_eq("busy_after_reset", 32'(busy), 32'd0);
      idle_bits(2.0);

      // 1: single byte
      send_frame(8'h11, 1'b1, BIT_PER, 8);
      idle_bits(1.0);
      check_eq("t1_data", 32'(data), 32'h11);
      check_eq("t1_valid_count", 32'(n_valid_seen), 32'd1);
      check_eq("t1_busy", 32'(busy), 32'd0);

      // 2: back-to-back frames
      send_frame(8'h00, 1'b1, BIT_PER, 8);
      send_frame(8'h02, 1'b1, BIT_PER, 8);
      idle_bits(1.0);
      check_eq("t2_data", 32'(data), 32'h02);
      check_eq("t2_valid_count", 32'(n_valid_seen), 32'd3);

      // 3: short glitch, IDLE exactly HALF+3 clocks after the falling edge
      @(negedge clk);
      #1 rx = 1'b0;
      fork
         begin
            #2000 rx = 1'b1;
         end
      join_none
      repeat (30) @(posedge clk);
      @(negedge clk);
      check_eq("t3_busy_mid", 32'(busy), 32'd1);
      repeat (HALF + 3 - 30) @(posedge clk);
      @(negedge clk);
      check_eq("t3_busy_idle", 32'(busy), 32'd0);
      idle_bits(1.0);
      check_eq("t3_no_strobe", 32'(n_valid_seen + n_ferr_seen), 32'd3);

      // 4: framing error, held-low line, then recovery
      send_frame(8'h55, 1'b0, BIT_PER, 8);
      #(19.0 * BIT_PER);
      idle_bits(2.0);
      check_eq("t4_ferr_count", 32'(n_ferr_seen), 32'd1);
      check_eq("t4_data_kept", 32'(data), 32'h02);
      send_frame(8'h81, 1'b1, BIT_PER, 8);
      idle_bits(1.0);
      check_eq("t4_data", 32'(data), 32'h81);
      check_eq("t4_valid_count", 32'(n_valid_seen), 32'd4);

      // 5: reset mid-frame abandons it
      send_frame(8'hA5, 1'b1, BIT_PER, 4);
      @(negedge clk);
      #1;
      nrst       = 1'b0;
      rx         = 1'b1;
      model_data = 8'h00;
      #1000;
      @(negedge clk);
      #1 nrst = 1'b1;
      idle_bits(2.0);
      check_eq("t5_data_cleared", 32'(data), 32'h00);
      send_frame(8'hA5, 1'b1, BIT_PER, 8);
      idle_bits(1.0);
      check_eq("t5_data", 32'(data), 32'hA5);
      check_eq("t5_valid_count", 32'(n_valid_seen), 32'd5);

      // 6: +/-3% baud error, back-to-back within each group
      v0 = n_valid_seen;
      for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + 16 * i), 1'b1, BIT_PER * 1.03, 8);
      idle_bits(1.0);
      for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + 16 * i), 1'b1, BIT_PER * 0.97, 8);
      idle_bits(1.0);
      check_eq("t6_valid_count", 32'(n_valid_seen - v0), 32'd16);
      check_eq("t6_data", 32'(data), 32'h81);

      // Randomised frames, rates, stop bits and gaps
      for (int i = 0; i < 24; i++) begin
         per = BIT_PER * (0.97 + 0.06 * real'($urandom_range(0, 1000)) / 1000.0);
         bad = ($urandom_range(0, 5) == 0);
         send_frame(8'($urandom), !bad, per, 8);
         if (bad) begin
            #(real'($urandom_range(0, 2)) * per);
            rx = 1'b1;
            #(per);
         end
         rx = 1'b1;
         #(real'($urandom_range(0, 2)) * per);
      end

      idle_bits(2.0);
      check_eq("pending_strobes", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
